// File: rtl/seg7_if.sv
// Bus between the CPU LED output register (master) and the 7-segment scan driver (slave).
// There is no valid/ready handshake: the master holds level signals that the
// driver samples on every clk. disp_data is captured only at frame boundaries.
// frame_done is a one-cycle pulse from the driver.
interface seg7_if;
  logic [23:0] disp_data;
  logic        disp_en;
  logic        lz_blank;
  logic        blink_en;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        frame_done;

  modport master (
    output disp_data, disp_en, lz_blank, blink_en,
    input  seg_out, an_out, frame_done
  );

  modport slave (
    input  disp_data, disp_en, lz_blank, blink_en,
    output seg_out, an_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode 7-segment driver showing a 24-bit value as 6 hex digits.
// The input value is latched only at frame boundaries, so a frame never mixes two values.
// Supports leading-zero blanking, a global enable and a whole-display blink.
module seg7_scan_driver #(
  parameter int CLK_DIV      = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  seg7_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          boundary;
  logic [31:0]   disp_word;
  logic [3:0]    nib;
  logic [7:0]    hi_zero;
  logic          lead_blank;
  logic          visible;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex nibble; dp always off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // Prescaler, digit scan index, frame-boundary latch and blink timebase.
  always_comb begin
    tick         = (presc_q == PRESC_MAX);
    boundary     = tick && (idx_q == 3'd7);
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    shadow_d     = shadow_q;
    frame_cnt_d  = frame_cnt_q;
    blink_ph_d   = blink_ph_q;
    frame_done_d = boundary;
    if (boundary) begin
      shadow_d = bus.disp_data;
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Anode/segment pattern for the digit currently selected by the scan index.
  always_comb begin
    disp_word  = {8'h00, shadow_q};
    nib        = disp_word[{idx_q, 2'b00} +: 4];
    // hi_zero[i]: nibbles i..5 of the latched value are all zero.
    hi_zero[7] = 1'b1;
    hi_zero[6] = 1'b1;
    hi_zero[5] = (shadow_q[23:20] == 4'h0);
    hi_zero[4] = hi_zero[5] && (shadow_q[19:16] == 4'h0);
    hi_zero[3] = hi_zero[4] && (shadow_q[15:12] == 4'h0);
    hi_zero[2] = hi_zero[3] && (shadow_q[11:8] == 4'h0);
    hi_zero[1] = hi_zero[2] && (shadow_q[7:4] == 4'h0);
    hi_zero[0] = hi_zero[1] && (shadow_q[3:0] == 4'h0);
    // Digit 0 is never blanked so a zero value still reads "0".
    lead_blank = bus.lz_blank && (idx_q != 3'd0) && hi_zero[idx_q];
    visible    = bus.disp_en && !(bus.blink_en && blink_ph_q) &&
                 (idx_q <= 3'd5) && !lead_blank;
    an_d       = visible ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d      = visible ? hex7(nib) : 8'hFF;
  end

  // State and registered outputs; reset darkens the display at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 24'h0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an_out     = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule
